// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV64 load/store unit: funct3 codes, FSM states
// and access-size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    // Lane width in bytes; only the low two funct3 bits encode the size.
    function automatic logic [3:0] size_from_funct3(input logic [1:0] size_code);
        case (size_code)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and doubleword memory bus of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_write_data;
    logic [XLEN-1:0] mem_read_data;
    logic            mem_read;
    logic            mem_write;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
               resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
               resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane handling: load extraction/extension, store merge into a
// doubleword, and alignment check.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] dword_i,
    input  logic [2:0]      offset_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_val_o,
    output logic [XLEN-1:0] merged_o,
    output logic            misaligned_o
);
    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [3:0]      size;

    assign shamt   = {offset_i, 3'b000};
    assign shifted = dword_i >> shamt;
    assign size    = size_from_funct3(funct3_i[1:0]);

    assign misaligned_o = |(offset_i & 3'(size - 4'd1));

    always_comb begin
        load_val_o = '0;
        case (funct3_i)
            F3_B:    load_val_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_val_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_val_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_D:    load_val_o = shifted;
            F3_BU:   load_val_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_val_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_WU:   load_val_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_val_o = '0;
        endcase
    end

    always_comb begin
        mask = '1;
        case (funct3_i[1:0])
            2'd0:    mask = {{(XLEN-8){1'b0}}, 8'hFF};
            2'd1:    mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            2'd2:    mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            default: mask = '1;
        endcase
    end

    // A doubleword store has a full mask at offset 0, so it reduces to wdata.
    assign merged_o = (dword_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one request at a time, read-modify-write for
// sub-doubleword stores against a doubleword-wide memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned XLEN      = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);
    lsu_state_t      state_q, state_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] dword_q, dword_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic            idle;
    logic [2:0]      la_offset, la_funct3;
    logic [XLEN-1:0] la_dword, load_val, merged;
    logic            misaligned, illegal_f3, out_of_range;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
    assign la_offset = idle ? bus.req_addr[2:0] : addr_q[2:0];
    assign la_funct3 = idle ? bus.req_funct3 : funct3_q;
    assign la_dword  = (state_q == ST_READ) ? bus.mem_read_data : dword_q;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .dword_i      (la_dword),
        .offset_i     (la_offset),
        .funct3_i     (la_funct3),
        .wdata_i      (wdata_q),
        .load_val_o   (load_val),
        .merged_o     (merged),
        .misaligned_o (misaligned)
    );

    assign illegal_f3   = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    assign out_of_range = {bus.req_addr[XLEN-1:3], 3'b000} > XLEN'(MEM_BYTES - 8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dword_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            dword_q  <= dword_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dword_d  = dword_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    fault_d  = illegal_f3 | out_of_range | misaligned;
                    if (illegal_f3 || out_of_range || misaligned)
                        state_d = ST_RESP;
                    else if (bus.req_store && bus.req_funct3 == F3_D)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                dword_d = bus.mem_read_data;
                if (store_q) begin
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready      = idle;
    assign bus.resp_valid     = (state_q == ST_RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_fault     = fault_q;
    assign bus.mem_read       = (state_q == ST_READ);
    assign bus.mem_write      = (state_q == ST_WRITE);
    assign bus.mem_address    = {addr_q[XLEN-1:3], 3'b000};
    assign bus.mem_write_data = merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    load_store_unit_if #(.XLEN(64)) bus ();

    load_store_unit #(.MEM_BYTES(1024), .XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:1023];
    logic        pl_we = 1'b0;
    int          pl_base = 0;
    logic [63:0] pl_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] wr_addr = '0;
    logic [63:0] wr_data = '0;

    int total = 0;
    int bad = 0;
    int lat, rd0, wr0;

    always_comb begin
        bus.mem_read_data = '0;
        if (bus.mem_read && bus.mem_address <= 64'd1016)
            for (int i = 0; i < 8; i++)
                bus.mem_read_data[i*8 +: 8] = mem[int'(bus.mem_address[9:0]) + i];
    end

    always @(posedge clk) begin
        if (bus.mem_read) rd_cnt <= rd_cnt + 1;
        if (bus.mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.mem_address;
            wr_data <= bus.mem_write_data;
            if (bus.mem_address <= 64'd1016)
                for (int i = 0; i < 8; i++)
                    mem[int'(bus.mem_address[9:0]) + i] <= bus.mem_write_data[i*8 +: 8];
        end else if (pl_we) begin
            for (int i = 0; i < 8; i++)
                mem[pl_base + i] <= pl_data[i*8 +: 8];
        end
    end

    function automatic logic [63:0] mem_dw(input int base);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mem[base + i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int base, input logic [63:0] data);
        @(negedge clk);
        pl_we = 1'b1; pl_base = base; pl_data = data;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    // Issue one request and wait (bounded) for resp_valid; lat = cycles after accept.
    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd);
        bit got;
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) got = 1;
        end
        if (!got) lat = 99;
    endtask

    task automatic take_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;

        #12;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_rdata", bus.resp_rdata, 64'd0);
        check("rst_fault", 64'(bus.resp_fault), 64'd0);
        check("rst_strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        rst_n = 1'b1;

        preload(16'h10, 64'h8887868584838281);
        preload(1016, 64'h0);

        do_req(1'b0, 3'b000, 64'h10, 64'h0);
        check("lb_rdata", bus.resp_rdata, 64'hFFFFFFFFFFFFFF81);
        check("lb_fault", 64'(bus.resp_fault), 64'd0);
        check("lb_latency", 64'(lat), 64'd2);
        check("lb_reads", 64'(rd_cnt - rd0), 64'd1);
        take_resp();

        do_req(1'b0, 3'b101, 64'h16, 64'h0);
        check("lhu_rdata", bus.resp_rdata, 64'h0000000000008887);
        take_resp();

        do_req(1'b0, 3'b010, 64'h14, 64'h0);
        check("lw_rdata", bus.resp_rdata, 64'hFFFFFFFF88878685);
        take_resp();

        do_req(1'b0, 3'b110, 64'h14, 64'h0);
        check("lwu_rdata", bus.resp_rdata, 64'h0000000088878685);
        take_resp();

        do_req(1'b1, 3'b000, 64'h13, 64'hAB);
        check("sb_latency", 64'(lat), 64'd3);
        check("sb_reads", 64'(rd_cnt - rd0), 64'd1);
        check("sb_writes", 64'(wr_cnt - wr0), 64'd1);
        check("sb_waddr", wr_addr, 64'h10);
        check("sb_wdata", wr_data, 64'h88878685AB838281);
        check("sb_rdata", bus.resp_rdata, 64'd0);
        check("sb_fault", 64'(bus.resp_fault), 64'd0);
        take_resp();

        do_req(1'b0, 3'b001, 64'h11, 64'h0);
        check("lh_mis_fault", 64'(bus.resp_fault), 64'd1);
        check("lh_mis_rdata", bus.resp_rdata, 64'd0);
        check("lh_mis_latency", 64'(lat), 64'd1);
        check("lh_mis_strobes", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'd0);
        take_resp();

        do_req(1'b1, 3'b011, 64'd1024, 64'h1);
        check("sd_oor_fault", 64'(bus.resp_fault), 64'd1);
        check("sd_oor_writes", 64'(wr_cnt - wr0), 64'd0);
        take_resp();

        do_req(1'b0, 3'b111, 64'h10, 64'h0);
        check("ld_f3_111_fault", 64'(bus.resp_fault), 64'd1);
        take_resp();

        do_req(1'b1, 3'b100, 64'h10, 64'h0);
        check("st_f3_1xx_fault", 64'(bus.resp_fault), 64'd1);
        check("st_f3_1xx_writes", 64'(wr_cnt - wr0), 64'd0);
        take_resp();

        do_req(1'b1, 3'b011, 64'd1016, 64'h0123456789ABCDEF);
        check("sd_top_latency", 64'(lat), 64'd2);
        check("sd_top_fault", 64'(bus.resp_fault), 64'd0);
        check("sd_top_reads", 64'(rd_cnt - rd0), 64'd0);
        check("sd_top_writes", 64'(wr_cnt - wr0), 64'd1);
        check("sd_top_waddr", wr_addr, 64'd1016);
        take_resp();

        do_req(1'b0, 3'b011, 64'd1016, 64'h0);
        check("ld_top_rdata", bus.resp_rdata, 64'h0123456789ABCDEF);
        take_resp();

        do_req(1'b0, 3'b011, 64'h10, 64'h0);
        check("ld_merged_rdata", bus.resp_rdata, 64'h88878685AB838281);
        held = bus.resp_rdata;
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b011;
        bus.req_addr = 64'h10; bus.req_wdata = 64'hDEAD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
            check("bp_rdata", bus.resp_rdata, 64'h88878685AB838281);
        end
        bus.req_valid = 1'b0;
        check("bp_ignored_req", 64'(wr_cnt - wr0), 64'd0);
        take_resp();

        // Reset asserted while the write strobe of a store is up.
        @(negedge clk);
        wr0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 64'h10; bus.req_wdata = 64'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 check("rw_write_strobe", 64'(bus.mem_write), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rw_strobes_dropped", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        check("rw_req_ready", 64'(bus.req_ready), 64'd1);
        check("rw_resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("rw_mem_unchanged", mem_dw(16'h10), 64'h88878685AB838281);
        check("rw_no_write", 64'(wr_cnt - wr0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 3'b100, 64'h10, 64'h0);
        check("post_rst_lbu", bus.resp_rdata, 64'h0000000000000081);
        take_resp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the 64-bit doubleword data memory.
- Accepts one RV64 load or store request at a time. Every memory access uses the doubleword-aligned base address.
- Handles sub-doubleword accesses:
  - loads: extract and sign- or zero-extend the lane;
  - stores: read-modify-write, because the memory only writes full doublewords.
- Returns a response carrying load data or a fault flag.

Parameters:
- MEM_BYTES, 1024, size of data memory in bytes. The highest legal base is MEM_BYTES-8.
- XLEN, 64, data and address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_store  input  1  1=store, 0=load.
- req_funct3  input  3  RISC-V funct3 size/sign code.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, least-significant bytes used.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  XLEN  extended load data; 0 for stores and faults.
- resp_fault  output  1  misaligned, out-of-range, or illegal funct3.
- mem_address  output  XLEN  doubleword base (req_addr & ~7).
- mem_write_data  output  XLEN  merged doubleword.
- mem_read_data  input  XLEN  combinational read data, valid while mem_read=1.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe; the write commits at the next rising edge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_read=0, mem_write=0;
  - all latched request registers cleared;
  - strobes drop immediately, so a write pending at the next edge does not commit.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch op, funct3, addr and wdata.
  - Fault → RESP.
  - Load, or store with funct3≠011 → READ.
  - Store doubleword (SD) → WRITE.
- READ:
  - mem_read=1 for exactly one cycle.
  - Capture mem_read_data into a doubleword register at the end of the cycle.
  - Load → RESP. Store → WRITE.
- WRITE:
  - mem_write=1 for exactly one cycle.
  - mem_write_data = captured doubleword with the target lane replaced by wdata; SD writes wdata directly.
  - → RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_fault are held stable until resp_ready=1.
  - On resp_ready, return to IDLE. The next request is accepted the following cycle; there is no IDLE bypass.
- Latency in cycles from the accept edge to resp_valid: fault 1, load 2, SD 2, SB/SH/SW 3.
- Offset and lane width:
  - offset = addr[2:0];
  - lane width = 1, 2, 4 or 8 bytes, from funct3[1:0];
  - lane = bytes [offset .. offset+size-1].
- Load funct3 codes:
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extend from the lane MSB;
  - 100 LBU, 101 LHU, 110 LWU: zero-extend;
  - 111 is illegal → fault.
- Store funct3 codes: 000 SB, 001 SH, 010 SW, 011 SD; 1xx is illegal → fault.
- Faults; the request completes with no memory strobe:
  - misaligned: offset not a multiple of the lane size;
  - out of range: base > MEM_BYTES-8;
  - illegal funct3.
- Byte order is little-endian: byte 0 = bits [7:0].
- mem_read and mem_write are never asserted together, and never outside READ/WRITE.
- Requests arriving while req_ready=0 are ignored; the upstream stage must hold them.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - state enum lsu_state_t;
  - function size_from_funct3.
- One combinational sub-module, lsu_lane_align:
  - inputs: doubleword, offset, funct3, wdata;
  - outputs: extended load value, merged store doubleword, misaligned flag.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Preload memory bytes 0x10..0x17 = 81 82 83 84 85 86 87 88. LB addr 0x10 → rdata 0xFFFFFFFFFFFFFF81, fault=0, resp_valid two cycles after accept.
- Same memory, LHU addr 0x16 → 0x0000000000008887. LW addr 0x14 → 0xFFFFFFFF88878685.
- SB wdata 0xAB to addr 0x13 → READ then WRITE of 0x88878685AB838281 at base 0x10, resp three cycles after accept, exactly one mem_write pulse.
- LH addr 0x11 → fault=1, rdata=0, no mem_read or mem_write, resp one cycle after accept. SD addr 1024 → fault=1.
- SD 0x0123456789ABCDEF to addr 1016 → accepted, single write at base 1016, resp after two cycles. A subsequent LD at 1016 returns the same value.
- Backpressure: hold resp_ready=0 for 5 cycles → resp outputs stable, req_ready=0. Then assert rst_n=0 during a WRITE cycle → strobes drop immediately and the memory word is unchanged.
